// File: rtl/tex_dcr_serializer.sv
// Texture-stage DCR initiator: snapshots one stage's texture config and replays it as a burst of DCR writes.
// Optional feature macro: TEX_DCR_MIP_TRIM_EN (stop the MIPOFF beats at the highest level the snapshot's logdims use).
`timescale 1ns/1ps
module tex_dcr_serializer #(
  parameter int                       DCR_ADDR_BITS = 12,
  parameter logic [DCR_ADDR_BITS-1:0] DCR_BASE      = 12'h100,
  parameter int                       ADDR_BITS     = 25,
  parameter int                       LOD_BITS      = 4,
  parameter int                       LOD_MAX       = 11,
  parameter int                       DIM_BITS      = 15,
  parameter int                       STAGE_BITS    = 2,
  localparam int NUM_LODS    = LOD_MAX + 1,
  localparam int MIPOFF_BITS = 2 * DIM_BITS + 1,
  localparam int WRAP_BITS   = 2,
  localparam int FORMAT_BITS = 3,
  localparam int FILTER_BITS = 1,
  localparam int DCRS_W      = NUM_LODS * MIPOFF_BITS + 2 * LOD_BITS + 2 * WRAP_BITS
                               + ADDR_BITS + FORMAT_BITS + FILTER_BITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [STAGE_BITS-1:0]    start_stage,
  input  logic [DCRS_W-1:0]        start_dcrs,
  output logic                     dcr_wr_valid,
  input  logic                     dcr_wr_ready,
  output logic [DCR_ADDR_BITS-1:0] dcr_wr_addr,
  output logic [31:0]              dcr_wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int OFF_FILTER = 0;
  localparam int OFF_FORMAT = OFF_FILTER + FILTER_BITS;
  localparam int OFF_ADDR   = OFF_FORMAT + FORMAT_BITS;
  localparam int OFF_WRAP0  = OFF_ADDR + ADDR_BITS;
  localparam int OFF_WRAP1  = OFF_WRAP0 + WRAP_BITS;
  localparam int OFF_LOG0   = OFF_WRAP1 + WRAP_BITS;
  localparam int OFF_LOG1   = OFF_LOG0 + LOD_BITS;
  localparam int OFF_MIP    = OFF_LOG1 + LOD_BITS;
  localparam int NUM_BEATS  = 6 + NUM_LODS;
  localparam int IDX_BITS   = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_start_ready;
  logic                     r_valid;
  logic [DCR_ADDR_BITS-1:0] r_addr;
  logic [31:0]              r_data;
  logic                     r_busy;
  logic                     r_done;
  logic [IDX_BITS-1:0]      r_index;
  logic [IDX_BITS-1:0]      r_last;
  logic [STAGE_BITS-1:0]    r_stage;
  logic [DCRS_W-1:0]        r_dcrs;
  logic [IDX_BITS-1:0]      w_next_index;

  // Beat payload for a given index, zero-extended to the 32-bit DCR data bus.
  function automatic logic [31:0] f_beat_data(input logic [IDX_BITS-1:0]   idx,
                                              input logic [STAGE_BITS-1:0] stage,
                                              input logic [DCRS_W-1:0]     dcrs);
    logic [31:0] d;
    int          mip;
    d   = 32'd0;
    mip = 0;
    case (idx)
      IDX_BITS'(0): d[STAGE_BITS-1:0] = stage;
      IDX_BITS'(1): d[ADDR_BITS-1:0]  = dcrs[OFF_ADDR +: ADDR_BITS];
      IDX_BITS'(2): begin
        d[0 +: LOD_BITS]  = dcrs[OFF_LOG0 +: LOD_BITS];
        d[16 +: LOD_BITS] = dcrs[OFF_LOG1 +: LOD_BITS];
      end
      IDX_BITS'(3): d[FORMAT_BITS-1:0] = dcrs[OFF_FORMAT +: FORMAT_BITS];
      IDX_BITS'(4): d[FILTER_BITS-1:0] = dcrs[OFF_FILTER +: FILTER_BITS];
      IDX_BITS'(5): begin
        d[0 +: WRAP_BITS]  = dcrs[OFF_WRAP0 +: WRAP_BITS];
        d[16 +: WRAP_BITS] = dcrs[OFF_WRAP1 +: WRAP_BITS];
      end
      default: begin
        mip = int'(idx) - 6;
        if (mip >= 0 && mip < NUM_LODS) begin
          d[MIPOFF_BITS-1:0] = dcrs[OFF_MIP + mip * MIPOFF_BITS +: MIPOFF_BITS];
        end else begin
          d = 32'd0;
        end
      end
    endcase
    return d;
  endfunction

`ifdef TEX_DCR_MIP_TRIM_EN
  // Last beat index when only the mip levels the texture actually uses are sent.
  function automatic logic [IDX_BITS-1:0] f_trim_last(input logic [DCRS_W-1:0] dcrs);
    logic [LOD_BITS-1:0] l0;
    logic [LOD_BITS-1:0] l1;
    logic [LOD_BITS-1:0] m;
    l0 = dcrs[OFF_LOG0 +: LOD_BITS];
    l1 = dcrs[OFF_LOG1 +: LOD_BITS];
    m  = (l0 > l1) ? l0 : l1;
    if (int'(m) > LOD_MAX) begin
      return IDX_BITS'(6 + LOD_MAX);
    end else begin
      return IDX_BITS'(6) + IDX_BITS'(m);
    end
  endfunction
`endif

  assign w_next_index = r_index + IDX_BITS'(1);

  // Burst sequencer: IDLE accepts a snapshot, SEND walks the beats, DONE pulses completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_start_ready <= 1'b1;
      r_valid       <= 1'b0;
      r_addr        <= '0;
      r_data        <= 32'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_index       <= '0;
      r_last        <= IDX_BITS'(NUM_BEATS - 1);
      r_stage       <= '0;
      r_dcrs        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_valid && r_start_ready) begin
            r_stage       <= start_stage;
            r_dcrs        <= start_dcrs;
`ifdef TEX_DCR_MIP_TRIM_EN
            r_last        <= f_trim_last(start_dcrs);
`else
            r_last        <= IDX_BITS'(NUM_BEATS - 1);
`endif
            r_index       <= '0;
            r_addr        <= DCR_BASE;
            r_data        <= 32'(start_stage);
            r_valid       <= 1'b1;
            r_busy        <= 1'b1;
            r_start_ready <= 1'b0;
            r_state       <= ST_SEND;
          end else begin
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
        ST_SEND: begin
          if (dcr_wr_ready) begin
            if (r_index == r_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              // addr/data only advance on a handshake, so they hold through stalls
              r_index <= w_next_index;
              r_addr  <= DCR_BASE + DCR_ADDR_BITS'(w_next_index);
              r_data  <= f_beat_data(w_next_index, r_stage, r_dcrs);
            end
          end
        end
        ST_DONE: begin
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_valid       <= 1'b0;
          r_done        <= 1'b0;
          r_busy        <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready  = r_start_ready;
  assign dcr_wr_valid = r_valid;
  assign dcr_wr_addr  = r_addr;
  assign dcr_wr_data  = r_data;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
